// File: rtl/fxp_addsub_pipe.sv
// Two-stage pipelined fixed-point adder/subtractor with per-beat signedness,
// rounding, saturation and sticky range-violation flags.
module fxp_addsub_pipe #(
  parameter int I1 = 2,
  parameter int F1 = 14,
  parameter int I2 = 2,
  parameter int F2 = 14,
  parameter int I3 = 2,
  parameter int F3 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [I1+F1-1:0] a,
  input  logic             s1,
  input  logic [I2+F2-1:0] b,
  input  logic             s2,
  input  logic             op,
  input  logic             rnd_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [I3+F3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic             udf_sticky
);

  localparam int FMAX = (F1 > F2) ? F1 : F2;
  localparam int IW   = ((I1 > I2) ? I1 : I2) + 2;
  localparam int W    = IW + FMAX;
  localparam int OW   = I3 + F3;
  localparam int XA   = W + F3 + 2;
  localparam int XB   = OW + 2;
  localparam int XW   = (XA > XB) ? XA : XB;
  localparam int HS   = (FMAX > 0) ? FMAX - 1 : 0;

  // Work at F3+FMAX fraction bits so one arithmetic right shift by FMAX floors to F3.
  localparam logic signed [XW-1:0] HALF = (FMAX > F3) ? (XW'(1) << HS) : '0;
  localparam logic signed [XW-1:0] SMAX = (XW'(1) << (OW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] SMIN = -(XW'(1) << (OW - 1));
  localparam logic signed [XW-1:0] UMAX = (XW'(1) << OW) - XW'(1);
  localparam logic signed [XW-1:0] UMIN = '0;

  logic                adv;
  logic signed [W-1:0] ea, eb, sum;
  logic                v1, sgn1, rnd1, sat1;
  logic signed [W-1:0] sum1;

  logic signed [XW-1:0] xs, rndadd, xr, hi, lo;
  logic                 ovf, udf;
  logic [OW-1:0]        cres;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    ea  = {{(W-I1-F1){s1 & a[I1+F1-1]}}, a};
    eb  = {{(W-I2-F2){s2 & b[I2+F2-1]}}, b};
    ea  = ea <<< (FMAX - F1);
    eb  = eb <<< (FMAX - F2);
    sum = op ? (ea - eb) : (ea + eb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      sum1 <= '0;
      sgn1 <= 1'b0;
      rnd1 <= 1'b0;
      sat1 <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      sum1 <= sum;
      sgn1 <= s1 | s2 | op;
      rnd1 <= rnd_mode;
      sat1 <= sat_en;
    end
  end

  always_comb begin
    xs     = {{(XW-W){sum1[W-1]}}, sum1};
    rndadd = '0;
    if (rnd1) rndadd = HALF;
    xr  = (xs <<< F3) + rndadd;
    xr  = xr >>> FMAX;
    hi  = sgn1 ? SMAX : UMAX;
    lo  = sgn1 ? SMIN : UMIN;
    ovf = xr > hi;
    udf = xr < lo;
    cres = xr[OW-1:0];
    if (sat1 && ovf) cres = hi[OW-1:0];
    else if (sat1 && udf) cres = lo[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      c         <= cres;
      sign      <= sgn1;
      overflow  <= ovf;
      underflow <= udf;
    end
  end

  // A flag raised by the beat consumed this edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (ovf_sticky & ~clr_sticky) | (out_valid & out_ready & overflow);
      udf_sticky <= (udf_sticky & ~clr_sticky) | (out_valid & out_ready & underflow);
    end
  end

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Directed self-checking bench for fxp_addsub_pipe at default Q2.14 + Q2.14 -> Q2.8.
module tb_fxp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, s1, s2, op, rnd_mode, sat_en;
  logic [15:0] a, b;
  logic        out_valid, out_ready, sign, overflow, underflow;
  logic [9:0]  c;
  logic        clr_sticky, ovf_sticky, udf_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  fxp_addsub_pipe #(.I1(2), .F1(14), .I2(2), .F2(14), .I3(2), .F3(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .s1(s1), .b(b), .s2(s2), .op(op), .rnd_mode(rnd_mode),
    .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .sign(sign), .overflow(overflow), .underflow(underflow),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  // Presents one beat, then leaves the result on the output (two edges later).
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs1,
                      input logic vs2, input logic vop, input logic vrnd, input logic vsat);
    a = va; b = vb; s1 = vs1; s2 = vs2; op = vop; rnd_mode = vrnd; sat_en = vsat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a = 16'h4000; b = 16'h2000;
    s1 = 1'b0; s2 = 1'b0; op = 1'b0; rnd_mode = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({out_valid, c, sign, overflow, underflow, ovf_sticky, udf_sticky} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b c=%h s=%b o=%b u=%b os=%b us=%b, expected all 0",
               out_valid, c, sign, overflow, underflow, ovf_sticky, udf_sticky);
    end
    rst = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_valid: cycle %0d got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_unsigned_add;
    a = 16'h4000; b = 16'h2000; s1 = 1'b0; s2 = 1'b0; op = 1'b0; rnd_mode = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_latency: out_valid after one edge got %b expected 0", out_valid);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({out_valid, c, sign, overflow, underflow} !== {1'b1, 10'h180, 3'b000}) begin
      n_fail++;
      $display("FAIL unsigned_add: got v=%b c=%h s=%b o=%b u=%b expected v=1 c=180 s=0 o=0 u=0",
               out_valid, c, sign, overflow, underflow);
    end
    @(posedge clk); #1;
    n_chk++;
    if ((out_valid !== 1'b0) || (ovf_sticky !== 1'b0)) begin
      n_fail++; $display("FAIL add_drain: got v=%b os=%b expected 0 0", out_valid, ovf_sticky);
    end
  endtask

  task automatic test_signed_overflow;
    send(16'h6000, 16'h6000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({out_valid, c, sign, overflow, underflow} !== {1'b1, 10'h1FF, 3'b110}) begin
      n_fail++;
      $display("FAIL ovf_sat: got v=%b c=%h s=%b o=%b u=%b expected v=1 c=1ff s=1 o=1 u=0",
               out_valid, c, sign, overflow, underflow);
    end
    @(posedge clk); #1;
    n_chk++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky_set: got %b expected 1", ovf_sticky);
    end
    send(16'h6000, 16'h6000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({c, overflow, underflow} !== {10'h300, 2'b10}) begin
      n_fail++; $display("FAIL ovf_wrap: got c=%h o=%b u=%b expected c=300 o=1 u=0", c, overflow, underflow);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_wins: got %b expected 1", ovf_sticky);
    end
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    n_chk++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: got %b expected 0", ovf_sticky);
    end
  endtask

  task automatic test_signed_underflow;
    send(16'h8000, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({out_valid, c, sign, overflow, underflow} !== {1'b1, 10'h200, 3'b101}) begin
      n_fail++;
      $display("FAIL udf_sat: got v=%b c=%h s=%b o=%b u=%b expected v=1 c=200 s=1 o=0 u=1",
               out_valid, c, sign, overflow, underflow);
    end
    @(posedge clk); #1;
    n_chk++;
    if ((udf_sticky !== 1'b1) || (ovf_sticky !== 1'b0)) begin
      n_fail++; $display("FAIL udf_sticky: got us=%b os=%b expected 1 0", udf_sticky, ovf_sticky);
    end
  endtask

  task automatic test_rounding;
    send(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({c, sign} !== {10'h000, 1'b0}) begin
      n_fail++; $display("FAIL round_trunc: got c=%h s=%b expected c=000 s=0", c, sign);
    end
    send(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({c, overflow} !== {10'h001, 1'b0}) begin
      n_fail++; $display("FAIL round_half_up: got c=%h o=%b expected c=001 o=0", c, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [9:0] expv [6] = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066};
    int         sent = 0;
    int         got  = 0;
    logic       stalled_prev = 1'b0;
    logic [9:0] c_prev = '0;
    logic       acc;
    s1 = 1'b0; s2 = 1'b0; op = 1'b0; rnd_mode = 1'b0; sat_en = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (sent < 6);
      a = 16'(16'h0400 * (sent + 1));
      b = 16'(16'h0040 * (sent + 1));
      #1;
      if (stalled_prev) begin
        n_chk++;
        if (c !== c_prev) begin
          n_fail++; $display("FAIL stall_stable: cycle %0d got c=%h expected %h", cyc, c, c_prev);
        end
      end
      if (out_valid && !out_ready) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready);
        end
      end
      stalled_prev = out_valid && !out_ready;
      c_prev = c;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_chk++;
        if (c !== expv[got]) begin
          n_fail++; $display("FAIL stream_order: beat %0d got c=%h expected %h", got, c, expv[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++;
    if (got != 6) begin
      n_fail++; $display("FAIL stream_count: got %0d beats expected 6", got);
    end
  endtask

  task automatic test_reset_mid;
    a = 16'h4000; b = 16'h2000; s1 = 1'b0; s2 = 1'b0; op = 1'b0; rnd_mode = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_chk++;
    if ({out_valid, c, udf_sticky, ovf_sticky} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b c=%h us=%b os=%b expected all 0", out_valid, c, udf_sticky, ovf_sticky);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_flush: got out_valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_add();
    test_signed_overflow();
    test_signed_underflow();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
